connect_board_engine: RTL

Parametrised successor to the 4x4 Connect-4 datapath. It merges column-height counting, disc placement, turn tracking and win/draw detection into one block for a ROWS x COLS board. Moves arrive through a valid/ready handshake. After each accepted move, a sequential scanner checks the four line directions through the placed cell, one neighbour per cycle. The block sits between the column-input logic and the display/status logic.

---
 rtl/connect_board_engine_if.sv | 23 ++
 rtl/connect_board_engine.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/connect_board_engine_if.sv
// Move handshake bundle between the column-input logic (master) and the board engine (slave).
// A move transfers on a rising edge where move_valid and move_ready are both high.
// The master holds move_column stable while move_valid is high. move_ready never depends on move_valid.
// move_ack and move_reject are single-cycle responses and are never high together.
interface connect_board_engine_if #(
  parameter int COL_W = 4
);
  logic             move_valid;
  logic [COL_W-1:0] move_column;
  logic             move_ready;
  logic             move_ack;
  logic             move_reject;

  modport master (
    output move_valid, move_column,
    input  move_ready, move_ack, move_reject
  );

  modport slave (
    input  move_valid, move_column,
    output move_ready, move_ack, move_reject
  );
endinterface

// File: rtl/connect_board_engine.sv
// Connect-N board engine: column heights, disc placement, turn tracking and a sequential
// four-direction win scanner that walks one neighbour per cycle out from the placed disc.
module connect_board_engine #(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int WIN_LEN = 4,
  parameter int COL_W   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   new_game,
  connect_board_engine_if.slave  mv,
  output logic [3:0]             last_row,
  output logic [ROWS*COLS-1:0]   gameboard,
  output logic [ROWS*COLS-1:0]   players_cells,
  output logic                   player_turn,
  output logic [1:0]             game_status,
  output logic                   busy,
  output logic [2:0]             state_dbg
);

  localparam int CELLS = ROWS * COLS;
  localparam int IDX_W = $clog2(CELLS);
  localparam int CI_W  = $clog2(COLS);
  // Signed neighbour coordinates: wide enough for row/col plus the largest step, so no wrap.
  localparam int IW    = 6;

  localparam logic [COL_W-1:0]     COLS_C  = COL_W'(COLS);
  localparam logic [3:0]           ROWS_H  = 4'(ROWS);
  localparam logic [7:0]           CELLS_C = 8'(CELLS);
  localparam logic [3:0]           K_LAST  = 4'(WIN_LEN - 1);
  localparam logic [4:0]           WIN_R   = 5'(WIN_LEN);
  localparam logic signed [IW-1:0] ROWS_S  = IW'(ROWS);
  localparam logic signed [IW-1:0] COLS_S  = IW'(COLS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PLACE   = 3'd1,
    S_SCAN    = 3'd2,
    S_RESOLVE = 3'd3,
    S_OVER    = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [3:0]        heights [COLS];
  logic [CI_W-1:0]   mv_col;
  logic [3:0]        mv_row;
  logic              mover;
  logic              win;
  logic [4:0]        run_cnt;
  logic [1:0]        dir;
  logic              side;
  logic [3:0]        k;
  logic [7:0]        move_count;
  logic              move_ack_q;
  logic              move_reject_q;

  logic              move_ready_c;
  logic              busy_c;
  logic              accept;
  logic              reject_now;
  logic [CI_W-1:0]   sel_col;
  logic [3:0]        sel_height;
  logic              col_ok;
  logic [IDX_W-1:0]  place_idx;

  logic signed [IW-1:0] dr, dc, kk, nr, nc;
  logic              in_board;
  logic [IDX_W-1:0]  cell_idx;
  logic              nb_match;
  logic              side_end;
  logic [4:0]        run_next;
  logic              dir_win;

  assign sel_col    = mv.move_column[CI_W-1:0];
  assign sel_height = heights[sel_col];
  assign col_ok     = (mv.move_column < COLS_C) && (sel_height != ROWS_H);
  assign place_idx  = IDX_W'(8'(heights[mv_col]) * 8'(COLS) + 8'(mv_col));

  // Neighbour at distance k along the current direction; the negative side flips the step.
  always_comb begin
    dr = '0;
    dc = '0;
    case (dir)
      2'd0:    begin dr = 6'sd0; dc = 6'sd1;  end
      2'd1:    begin dr = 6'sd1; dc = 6'sd0;  end
      2'd2:    begin dr = 6'sd1; dc = 6'sd1;  end
      default: begin dr = 6'sd1; dc = -6'sd1; end
    endcase
    if (side) begin
      dr = -dr;
      dc = -dc;
    end
    kk       = $signed({2'b00, k});
    nr       = $signed({2'b00, mv_row}) + dr * kk;
    nc       = $signed({{(IW-CI_W){1'b0}}, mv_col}) + dc * kk;
    in_board = !nr[IW-1] && (nr < ROWS_S) && !nc[IW-1] && (nc < COLS_S);
    cell_idx = IDX_W'(8'(nr[3:0]) * 8'(COLS) + 8'(nc[3:0]));
    nb_match = in_board && gameboard[cell_idx] && (players_cells[cell_idx] == mover);
    side_end = !nb_match || (k == K_LAST);
    run_next = run_cnt + (nb_match ? 5'd1 : 5'd0);
    dir_win  = (run_next >= WIN_R);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n      = state;
    move_ready_c = 1'b0;
    busy_c       = 1'b0;
    accept       = 1'b0;
    reject_now   = 1'b0;
    case (state)
      S_IDLE: begin
        move_ready_c = reset && (game_status == 2'd0) && !new_game;
        if (move_ready_c && mv.move_valid) begin
          if (col_ok) begin
            accept  = 1'b1;
            state_n = S_PLACE;
          end else begin
            reject_now = 1'b1;
          end
        end
      end
      S_PLACE: begin
        busy_c  = 1'b1;
        state_n = S_SCAN;
      end
      S_SCAN: begin
        busy_c = 1'b1;
        if (side_end && side && (dir_win || dir == 2'd3)) state_n = S_RESOLVE;
      end
      S_RESOLVE: begin
        busy_c  = 1'b1;
        state_n = (win || move_count == CELLS_C) ? S_OVER : S_IDLE;
      end
      S_OVER:  state_n = S_OVER;
      default: state_n = S_IDLE;
    endcase
    if (new_game) begin
      state_n    = S_IDLE;
      accept     = 1'b0;
      reject_now = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gameboard     <= '0;
      players_cells <= '0;
      for (int i = 0; i < COLS; i++) heights[i] <= '0;
      last_row      <= '0;
      player_turn   <= 1'b0;
      game_status   <= 2'd0;
      move_count    <= '0;
      mv_col        <= '0;
      mv_row        <= '0;
      mover         <= 1'b0;
      win           <= 1'b0;
      run_cnt       <= '0;
      dir           <= '0;
      side          <= 1'b0;
      k             <= '0;
      move_ack_q    <= 1'b0;
      move_reject_q <= 1'b0;
    end else if (new_game) begin
      gameboard     <= '0;
      players_cells <= '0;
      for (int i = 0; i < COLS; i++) heights[i] <= '0;
      last_row      <= '0;
      player_turn   <= 1'b0;
      game_status   <= 2'd0;
      move_count    <= '0;
      win           <= 1'b0;
      run_cnt       <= '0;
      dir           <= '0;
      side          <= 1'b0;
      k             <= '0;
      move_ack_q    <= 1'b0;
      move_reject_q <= 1'b0;
    end else begin
      move_ack_q    <= 1'b0;
      move_reject_q <= reject_now;
      case (state)
        S_IDLE: begin
          if (accept) begin
            mv_col <= sel_col;
            mover  <= player_turn;
            win    <= 1'b0;
          end
        end
        S_PLACE: begin
          gameboard[place_idx]     <= 1'b1;
          players_cells[place_idx] <= mover;
          last_row                 <= heights[mv_col];
          mv_row                   <= heights[mv_col];
          heights[mv_col]          <= heights[mv_col] + 4'd1;
          move_count               <= move_count + 8'd1;
          run_cnt                  <= 5'd1;
          dir                      <= 2'd0;
          side                     <= 1'b0;
          k                        <= 4'd1;
        end
        S_SCAN: begin
          run_cnt <= run_next;
          if (!side_end) begin
            k <= k + 4'd1;
          end else if (!side) begin
            side <= 1'b1;
            k    <= 4'd1;
          end else if (dir_win) begin
            win <= 1'b1;
          end else if (dir != 2'd3) begin
            dir     <= dir + 2'd1;
            side    <= 1'b0;
            k       <= 4'd1;
            run_cnt <= 5'd1;
          end
        end
        S_RESOLVE: begin
          move_ack_q <= 1'b1;
          if (win)                          game_status <= mover ? 2'd2 : 2'd1;
          else if (move_count == CELLS_C)   game_status <= 2'd3;
          else                              player_turn <= ~player_turn;
        end
        default: ;
      endcase
    end
  end

  assign mv.move_ready  = move_ready_c;
  assign mv.move_ack    = move_ack_q;
  assign mv.move_reject = move_reject_q;
  assign busy           = busy_c;
  assign state_dbg      = state;

endmodule
